// File: rtl/ram_arb2.sv
// Two-master round-robin arbiter in front of a single pipelined RAM port, with in-order response routing.
// Optional contention counter enabled by defining RAM_ARB_PERF_EN; otherwise perf_conflicts is tied to 0.
module ram_arb2 #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic          m0_err,
    output logic [31:0]   m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic          m1_err,
    output logic [31:0]   m1_rdata,

    output logic          s_req,
    output logic          s_we,
    output logic [3:0]    s_be,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdata,
    input  logic          s_gnt,
    input  logic          s_rvalid,
    input  logic          s_err,
    input  logic [31:0]   s_rdata,

    output logic [31:0]   perf_conflicts,
    output logic          dbg_state
);

    // Handshake: a request transfers in the cycle where req and gnt are both 1; the
    // requester keeps req and payload stable until then. rvalid is a one-cycle pulse
    // with no back-pressure, and responses arrive in the order requests were granted.

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_gnt_q, last_gnt_d;
    logic [1:0] fifo_q, fifo_d;          // bit 0 is the head (oldest owner)
    logic [1:0] fifo_cnt_q, fifo_cnt_d;

    logic fifo_empty;
    logic fifo_full;
    logic other_req;
    logic rr_sel;
    logic s_req_int;
    logic gnt_fire;
    logic resp_hit;
    logic owner;
    logic push;
    logic pop;

    always_comb begin
        fifo_empty = (fifo_cnt_q == 2'd0);
        fifo_full  = (fifo_cnt_q == 2'd2);
        other_req  = sel_q ? m0_req : m1_req;
        // On a tie the master that was not granted last goes first.
        rr_sel     = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
        s_req_int  = (state_q == REQ) && !fifo_full;
        gnt_fire   = s_req_int && s_gnt;
        resp_hit   = s_rvalid && (!fifo_empty || gnt_fire);
        owner      = fifo_empty ? sel_q : fifo_q[0];
        // A same-cycle response to a grant with nothing outstanding is consumed directly.
        push       = gnt_fire && !(fifo_empty && s_rvalid);
        pop        = s_rvalid && !fifo_empty;
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    sel_d   = rr_sel;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (gnt_fire) begin
                    last_gnt_d = sel_q;
                    if (other_req) begin
                        sel_d = ~sel_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d     = fifo_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10: begin
                fifo_d[fifo_cnt_q[0]] = sel_q;
                fifo_cnt_d            = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo_d[0]  = fifo_q[1];
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                fifo_d[0] = (fifo_cnt_q == 2'd1) ? sel_q : fifo_q[1];
                fifo_d[1] = sel_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            fifo_q     <= 2'b00;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_gnt_q <= last_gnt_d;
            fifo_q     <= fifo_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Every output is forced low while reset is held, including the pass-through paths.
    always_comb begin
        s_req     = !rst && s_req_int;
        s_we      = rst ? 1'b0 : (sel_q ? m1_we : m0_we);
        s_be      = rst ? 4'h0 : (sel_q ? m1_be : m0_be);
        s_addr    = rst ? '0 : (sel_q ? m1_addr : m0_addr);
        s_wdata   = rst ? 32'h0 : (sel_q ? m1_wdata : m0_wdata);
        m0_gnt    = !rst && gnt_fire && !sel_q;
        m1_gnt    = !rst && gnt_fire && sel_q;
        m0_rvalid = !rst && resp_hit && !owner;
        m1_rvalid = !rst && resp_hit && owner;
        m0_err    = !rst && resp_hit && !owner && s_err;
        m1_err    = !rst && resp_hit && owner && s_err;
        m0_rdata  = rst ? 32'h0 : s_rdata;
        m1_rdata  = rst ? 32'h0 : s_rdata;
        dbg_state = !rst && (state_q == REQ);
    end

`ifdef RAM_ARB_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (m0_req && m1_req && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 32'h0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflicts = rst ? 32'h0 : perf_q;
`else
    assign perf_conflicts = 32'h0;
`endif

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2: a per-cycle vector table from reset, then a hand-written
// reset-during-transaction sequence. Set RAM_ARB_PERF_EN to match the RTL build.
module tb_ram_arb2;

    localparam int AW = 32;
`ifdef RAM_ARB_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [31:0] M0_ADDR  = 32'h0000_0010;
    localparam logic [31:0] M1_ADDR  = 32'h0000_0020;
    localparam logic [31:0] M0_WDATA = 32'h1234_5678;
    localparam logic [31:0] M1_WDATA = 32'hCAFE_0001;
    localparam logic [3:0]  M0_BE    = 4'hF;
    localparam logic [3:0]  M1_BE    = 4'h3;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [3:0]    m0_be;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [3:0]    m1_be;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata, m1_rdata;
    logic          s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [3:0]    s_be;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rdata;
    logic [31:0]   perf_conflicts;
    logic          dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    ram_arb2 #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
        .perf_conflicts(perf_conflicts), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        m0_req;
        logic        m1_req;
        logic        s_gnt;
        logic        s_rvalid;
        logic        s_err;
        logic [31:0] s_rdata;
        logic        e_s_req;
        logic [31:0] e_addr;
        logic [1:0]  e_gnt;     // {m1, m0}
        logic [1:0]  e_rvalid;  // {m1, m0}
        logic [1:0]  e_err;     // {m1, m0}
        logic [31:0] e_perf;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic r, input logic q0, input logic q1, input logic g,
                                input logic rv, input logic er, input logic [31:0] rd,
                                input logic esr, input logic [31:0] ea, input logic [1:0] eg,
                                input logic [1:0] erv, input logic [1:0] eer, input int ep);
        vec_t v;
        v.rst = r; v.m0_req = q0; v.m1_req = q1; v.s_gnt = g; v.s_rvalid = rv;
        v.s_err = er; v.s_rdata = rd; v.e_s_req = esr; v.e_addr = ea; v.e_gnt = eg;
        v.e_rvalid = erv; v.e_err = eer;
        v.e_perf = PERF_EN ? 32'(ep) : 32'h0;
        return v;
    endfunction

    // Driver tasks
    task automatic drive(input logic r, input logic q0, input logic q1, input logic g,
                         input logic rv, input logic er, input logic [31:0] rd);
        rst = r; m0_req = q0; m1_req = q1; s_gnt = g; s_rvalid = rv; s_err = er; s_rdata = rd;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  eb;
        logic        ewe;
        logic [31:0] erd;
        ea  = v.rst ? 32'h0 : v.e_addr;
        ew  = v.rst ? 32'h0 : ((v.e_addr == M0_ADDR) ? M0_WDATA : M1_WDATA);
        eb  = v.rst ? 4'h0 : ((v.e_addr == M0_ADDR) ? M0_BE : M1_BE);
        ewe = v.rst ? 1'b0 : (v.e_addr == M1_ADDR);
        erd = v.rst ? 32'h0 : v.s_rdata;
        chk("s_req", idx, {31'h0, s_req}, {31'h0, v.e_s_req});
        chk("gnt", idx, {30'h0, m1_gnt, m0_gnt}, {30'h0, v.e_gnt});
        chk("rvalid", idx, {30'h0, m1_rvalid, m0_rvalid}, {30'h0, v.e_rvalid});
        chk("err", idx, {30'h0, m1_err, m0_err}, {30'h0, v.e_err});
        chk("m0_rdata", idx, m0_rdata, erd);
        chk("m1_rdata", idx, m1_rdata, erd);
        chk("perf", idx, perf_conflicts, v.e_perf);
        if (v.rst || v.e_s_req) begin
            chk("s_addr", idx, s_addr, ea);
            chk("s_wdata", idx, s_wdata, ew);
            chk("s_be", idx, {28'h0, s_be}, {28'h0, eb});
            chk("s_we", idx, {31'h0, s_we}, {31'h0, ewe});
        end
    endtask

    initial begin
        m0_we = 1'b0; m0_be = M0_BE; m0_addr = M0_ADDR; m0_wdata = M0_WDATA;
        m1_we = 1'b1; m1_be = M1_BE; m1_addr = M1_ADDR; m1_wdata = M1_WDATA;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        //           rst q0 q1 gnt rv er rdata          s_req addr      gnt    rvalid  err    perf
        tbl[0]  = mk(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 0, 32'h0,   2'b00, 2'b00, 2'b00, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,   2'b00, 2'b00, 2'b00, 0);
        // both request from reset: m0 first, m1 back-to-back
        tbl[2]  = mk(0, 1, 1, 0, 0, 0, 32'h0,         0, 32'h0,   2'b00, 2'b00, 2'b00, 0);
        tbl[3]  = mk(0, 1, 1, 1, 0, 0, 32'h0,         1, M0_ADDR, 2'b01, 2'b00, 2'b00, 1);
        tbl[4]  = mk(0, 0, 1, 1, 0, 0, 32'h0,         1, M1_ADDR, 2'b10, 2'b00, 2'b00, 2);
        // two queued responses returned in grant order, then a stray one
        tbl[5]  = mk(0, 0, 0, 0, 1, 0, 32'h1111_1111, 0, 32'h0,   2'b00, 2'b01, 2'b00, 2);
        tbl[6]  = mk(0, 0, 0, 0, 1, 1, 32'h2222_2222, 0, 32'h0,   2'b00, 2'b10, 2'b10, 2);
        tbl[7]  = mk(0, 0, 0, 0, 1, 1, 32'h3333_3333, 0, 32'h0,   2'b00, 2'b00, 2'b00, 2);
        // lone m0 read with same-cycle grant and response
        tbl[8]  = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,   2'b00, 2'b00, 2'b00, 2);
        tbl[9]  = mk(0, 1, 0, 1, 1, 0, 32'hDEAD_BEEF, 1, M0_ADDR, 2'b01, 2'b01, 2'b00, 2);
        // slave stalls 5 cycles with m0 selected while m1 waits
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,   2'b00, 2'b00, 2'b00, 2);
        tbl[11] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, M0_ADDR, 2'b00, 2'b00, 2'b00, 2);
        tbl[12] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, M0_ADDR, 2'b00, 2'b00, 2'b00, 3);
        tbl[13] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, M0_ADDR, 2'b00, 2'b00, 2'b00, 4);
        tbl[14] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, M0_ADDR, 2'b00, 2'b00, 2'b00, 5);
        tbl[15] = mk(0, 1, 1, 0, 0, 0, 32'h0,         1, M0_ADDR, 2'b00, 2'b00, 2'b00, 6);
        // two grants fill the owner FIFO, s_req stalls until a response pops
        tbl[16] = mk(0, 1, 1, 1, 0, 0, 32'h0,         1, M0_ADDR, 2'b01, 2'b00, 2'b00, 7);
        tbl[17] = mk(0, 1, 1, 1, 0, 0, 32'h0,         1, M1_ADDR, 2'b10, 2'b00, 2'b00, 8);
        tbl[18] = mk(0, 1, 0, 1, 0, 0, 32'h0,         0, 32'h0,   2'b00, 2'b00, 2'b00, 9);
        tbl[19] = mk(0, 1, 0, 1, 1, 0, 32'hAAAA_0001, 0, 32'h0,   2'b00, 2'b01, 2'b00, 9);
        tbl[20] = mk(0, 1, 0, 1, 1, 0, 32'hBBBB_0002, 1, M0_ADDR, 2'b01, 2'b10, 2'b00, 9);
        tbl[21] = mk(0, 0, 0, 0, 1, 0, 32'hCCCC_0003, 0, 32'h0,   2'b00, 2'b01, 2'b00, 9);

        @(posedge clk);
        #1;
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].m0_req, tbl[i].m1_req, tbl[i].s_gnt,
                  tbl[i].s_rvalid, tbl[i].s_err, tbl[i].s_rdata);
            @(negedge clk);
            check_vec(i, tbl[i]);
            @(posedge clk);
            #1;
        end

        // Reset while in REQ with one response outstanding
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("h_idle_s_req", 100, {31'h0, s_req}, 32'h0);
        @(posedge clk); #1;

        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("h_m0_gnt", 101, {31'h0, m0_gnt}, 32'h1);
        chk("h_perf_pre", 101, perf_conflicts, PERF_EN ? 32'd9 : 32'd0);
        @(posedge clk); #1;

        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA);
        @(negedge clk);
        chk("h_rst_outs", 102,
            {s_req, s_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, dbg_state},
            32'h0);
        chk("h_rst_addr", 102, s_addr, 32'h0);
        chk("h_rst_rdata", 102, m0_rdata | m1_rdata, 32'h0);
        chk("h_rst_perf", 102, perf_conflicts, 32'h0);
        @(posedge clk); #1;

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7777_0000);
        @(negedge clk);
        chk("h_stray_rvalid", 103, {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("h_post_s_req", 103, {31'h0, s_req}, 32'h0);
        chk("h_post_gnt", 103, {30'h0, m1_gnt, m0_gnt}, 32'h0);
        chk("h_post_perf", 103, perf_conflicts, 32'h0);
        @(posedge clk); #1;

        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("h_tie_idle", 104, {31'h0, s_req}, 32'h0);
        @(posedge clk); #1;

        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("h_tie_addr", 105, s_addr, M0_ADDR);
        chk("h_tie_gnt", 105, {30'h0, m1_gnt, m0_gnt}, 32'h1);
        chk("h_tie_perf", 105, perf_conflicts, PERF_EN ? 32'd1 : 32'd0);
        @(posedge clk); #1;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
